rom_port_arbiter: RTL

Single-ported front end for the combinational instruction ROM, sharing it between the instruction-fetch port and a data-read port (lw from code space, debug dump). Arbitrates one access per cycle with fetch priority and a starvation guard, registers the ROM address, returns data one cycle after grant, and converts `accessable=0` into a per-port fault plus a sticky fault-capture register. Sits between the CPU's fetch/memory stages and the ROM.

---
 rtl/rom_port_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational instruction ROM between the
// instruction-fetch port and a data-read port. One access per cycle, fetch
// has priority, a streak counter stops fetch from starving the data port.
// The granted address is registered toward the ROM, the response comes back
// the cycle after the grant, and inaccessible addresses become a per-port
// fault plus a sticky first-fault capture.
//
// Handshake: a port holds req and addr stable until it sees gnt=1 in the
// same cycle; the access is then committed and rvalid arrives exactly one
// cycle later. Responses have no backpressure and must be accepted on arrival.
module rom_port_arbiter #(
  parameter int IF_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_fault,
  input  logic        dr_req,
  input  logic [31:0] dr_addr,
  output logic        dr_gnt,
  output logic        dr_rvalid,
  output logic [31:0] dr_rdata,
  output logic        dr_fault,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_accessable,
  output logic        flt_valid,
  output logic [31:0] flt_addr,
  output logic        flt_src,
  input  logic        flt_clr
);

  localparam logic [3:0] BURST_MAX = 4'(IF_BURST_MAX);

  logic [31:0] addr_q;
  logic        src_q;
  logic        vld_q;
  logic [3:0]  streak;
  logic        both_req;
  logic        dr_wins;
  logic        resp_fault;

  // Arbitration: fetch wins ties unless it has used up its burst allowance.
  // Grants depend only on requests and streak, never on ROM outputs.
  always_comb begin
    both_req = if_req & dr_req;
    dr_wins  = both_req & (streak == BURST_MAX);
    if_gnt   = reset & if_req & ~dr_wins;
    dr_gnt   = reset & dr_req & (~if_req | dr_wins);
  end

  // Access register: capture the granted address and source port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= 32'h0;
      src_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else if (if_gnt) begin
      addr_q <= if_addr;
      src_q  <= 1'b0;
      vld_q  <= 1'b1;
    end else if (dr_gnt) begin
      addr_q <= dr_addr;
      src_q  <= 1'b1;
      vld_q  <= 1'b1;
    end else begin
      vld_q  <= 1'b0;
    end
  end

  // Starvation guard: count fetch wins only while the data port is waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      streak <= 4'd0;
    end else if (!dr_req || dr_gnt) begin
      streak <= 4'd0;
    end else if (if_gnt && streak != BURST_MAX) begin
      streak <= streak + 4'd1;
    end
  end

  assign rom_addr = addr_q;

  // Response steering: only the port that owns the access sees anything.
  always_comb begin
    resp_fault = vld_q & ~rom_accessable;
    if_rvalid  = vld_q & ~src_q;
    dr_rvalid  = vld_q & src_q;
    if_fault   = if_rvalid & ~rom_accessable;
    dr_fault   = dr_rvalid & ~rom_accessable;
    if_rdata   = (if_rvalid && rom_accessable) ? rom_data : 32'h0;
    dr_rdata   = (dr_rvalid && rom_accessable) ? rom_data : 32'h0;
  end

  // Sticky first-fault capture; a clear coinciding with a new fault keeps
  // the new fault rather than losing it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flt_valid <= 1'b0;
      flt_addr  <= 32'h0;
      flt_src   <= 1'b0;
    end else if (resp_fault && (!flt_valid || flt_clr)) begin
      flt_valid <= 1'b1;
      flt_addr  <= addr_q;
      flt_src   <= src_q;
    end else if (flt_clr) begin
      flt_valid <= 1'b0;
    end
  end

endmodule
